// File: rtl/dmem_map_pkg.sv
// Address map, MMIO offsets and reset values shared by the data-memory responder.
package dmem_map_pkg;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_e;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [2:0] OFF_LED    = 3'd0;
    localparam logic [2:0] OFF_IN     = 3'd1;
    localparam logic [2:0] OFF_TIMER  = 3'd2;
    localparam logic [2:0] OFF_CMP    = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    localparam int STATUS_TICK_BIT = 0;

    localparam logic [3:0] LED_RST = 4'h0;

    function automatic region_e decode_addr(
        input logic [31:0] addr,
        input int unsigned depth
    );
        if (!addr[31] && (addr < depth)) return REGION_RAM;
        if (addr[31:3] == MMIO_BASE[31:3]) return REGION_MMIO;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/mmio_debounce.sv
// One input bit: 2-flop synchroniser followed by a stable-count debouncer.
module mmio_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          dbn_q, dbn_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = din;
        s2_d  = s1_q;
        dbn_d = dbn_q;
        cnt_d = '0;
        // Any sample agreeing with the output restarts the run.
        if (s2_q != dbn_q) begin
            if (cnt_q == CNT_LAST) begin
                dbn_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dbn_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            dbn_q <= dbn_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = dbn_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// CPU data-memory responder: word RAM plus LED/input/timer MMIO page.
// Timer, compare, STATUS and TICK_IRQ exist only when MMIO_TIMER_EN is defined.
module dmem_mmio_responder
    import dmem_map_pkg::*;
#(
    parameter int RAM_DEPTH       = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TIMER_W         = 32
) (
    input  logic        CK_REF,
    input  logic        RST_N,
    input  logic [31:0] MEM_ACCESS_ADDRESS_BUS,
    input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
    input  logic        MEM_ACCESS_READ_WRN,
    output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
    input  logic [3:0]  SW_IN,
    input  logic [3:0]  BTN_IN,
    output logic [3:0]  LED_OUT,
    output logic        TICK_IRQ,
    output logic        BUS_ERR
);

    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    region_e       region;
    logic [2:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic          wr_en;
    logic          mmio_wr;

    always_comb begin
        region   = decode_addr(MEM_ACCESS_ADDRESS_BUS, RAM_DEPTH);
        mmio_off = MEM_ACCESS_ADDRESS_BUS[2:0];
        ram_idx  = MEM_ACCESS_ADDRESS_BUS[AW-1:0];
        wr_en    = !MEM_ACCESS_READ_WRN;
        mmio_wr  = wr_en && (region == REGION_MMIO);
    end

    logic [31:0] ram_q [RAM_DEPTH];
    logic [31:0] ram_d [RAM_DEPTH];
    logic [3:0]  led_q, led_d;
    logic        bus_err_q, bus_err_d;

    always_comb begin
        ram_d = ram_q;
        if (wr_en && (region == REGION_RAM)) begin
            ram_d[ram_idx] = MEM_ACCESS_DATA_OUT_BUS;
        end
        led_d = led_q;
        if (mmio_wr && (mmio_off == OFF_LED)) begin
            led_d = MEM_ACCESS_DATA_OUT_BUS[3:0];
        end
        bus_err_d = bus_err_q || (region == REGION_NONE);
    end

    always_ff @(posedge CK_REF) begin
        if (!RST_N) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram_q[i] <= '0;
            end
            led_q     <= LED_RST;
            bus_err_q <= 1'b0;
        end else begin
            ram_q     <= ram_d;
            led_q     <= led_d;
            bus_err_q <= bus_err_d;
        end
    end

    logic [7:0] raw_in;
    logic [7:0] in_dbn;

    assign raw_in = {BTN_IN, SW_IN};

    for (genvar g = 0; g < 8; g++) begin : g_dbn
        mmio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_dbn (
            .clk  (CK_REF),
            .rst_n(RST_N),
            .din  (raw_in[g]),
            .dout (in_dbn[g])
        );
    end

    logic [31:0] timer_rd;
    logic [31:0] cmp_rd;
    logic [31:0] status_rd;

`ifdef MMIO_TIMER_EN
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] cmp_q, cmp_d;
    logic               flag_q, flag_d;
    logic               irq_q, irq_d;
    logic               timer_wr, cmp_wr, stat_w1c, hit;

    always_comb begin
        timer_wr = mmio_wr && (mmio_off == OFF_TIMER);
        cmp_wr   = mmio_wr && (mmio_off == OFF_CMP);
        stat_w1c = mmio_wr && (mmio_off == OFF_STATUS)
                   && MEM_ACCESS_DATA_OUT_BUS[STATUS_TICK_BIT];
        // A timer clear on the match cycle suppresses the event.
        hit      = (timer_q == cmp_q) && !timer_wr;
        timer_d  = timer_wr ? '0 : timer_q + 1'b1;
        cmp_d    = cmp_wr ? MEM_ACCESS_DATA_OUT_BUS[TIMER_W-1:0] : cmp_q;
        irq_d    = hit;
        flag_d   = flag_q;
        if (hit) begin
            flag_d = 1'b1;
        end else if (stat_w1c) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge CK_REF) begin
        if (!RST_N) begin
            timer_q <= '0;
            cmp_q   <= '1;
            flag_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            flag_q  <= flag_d;
            irq_q   <= irq_d;
        end
    end

    assign TICK_IRQ  = irq_q;
    assign timer_rd  = 32'(timer_q);
    assign cmp_rd    = 32'(cmp_q);
    assign status_rd = 32'(flag_q) << STATUS_TICK_BIT;
`else
    assign TICK_IRQ  = 1'b0;
    assign timer_rd  = '0;
    assign cmp_rd    = '0;
    assign status_rd = '0;
`endif

    always_comb begin
        MEM_ACCESS_DATA_IN_BUS = '0;
        case (region)
            REGION_RAM: MEM_ACCESS_DATA_IN_BUS = ram_q[ram_idx];
            REGION_MMIO: begin
                case (mmio_off)
                    OFF_LED:    MEM_ACCESS_DATA_IN_BUS = {28'b0, led_q};
                    OFF_IN:     MEM_ACCESS_DATA_IN_BUS = {24'b0, in_dbn};
                    OFF_TIMER:  MEM_ACCESS_DATA_IN_BUS = timer_rd;
                    OFF_CMP:    MEM_ACCESS_DATA_IN_BUS = cmp_rd;
                    OFF_STATUS: MEM_ACCESS_DATA_IN_BUS = status_rd;
                    default:    MEM_ACCESS_DATA_IN_BUS = '0;
                endcase
            end
            default: MEM_ACCESS_DATA_IN_BUS = '0;
        endcase
    end

    assign LED_OUT = led_q;
    assign BUS_ERR = bus_err_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder (DEBOUNCE_CYCLES=4).
// Honours MMIO_TIMER_EN the same way the design does.
module tb_dmem_mmio_responder;

    localparam int D     = 4;
    localparam int DEPTH = 16;

    logic        ck    = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        rd_wrn = 1'b1;
    logic [3:0]  sw  = '0;
    logic [3:0]  btn = '0;
    logic [31:0] rdata;
    logic [3:0]  led;
    logic        irq;
    logic        berr;

    int errors = 0;
    int checks = 0;

    always #5 ck = ~ck;

    dmem_mmio_responder #(
        .RAM_DEPTH      (DEPTH),
        .DEBOUNCE_CYCLES(D),
        .TIMER_W        (32)
    ) dut (
        .CK_REF                 (ck),
        .RST_N                  (rst_n),
        .MEM_ACCESS_ADDRESS_BUS (addr),
        .MEM_ACCESS_DATA_OUT_BUS(wdata),
        .MEM_ACCESS_READ_WRN    (rd_wrn),
        .MEM_ACCESS_DATA_IN_BUS (rdata),
        .SW_IN                  (sw),
        .BTN_IN                 (btn),
        .LED_OUT                (led),
        .TICK_IRQ               (irq),
        .BUS_ERR                (berr)
    );

    // Reference model state
    logic [31:0] mram [DEPTH];
    logic [3:0]  mled;
    logic [7:0]  mdbn;
    logic [31:0] mtimer, mcmp;
    logic        mflag, mirq, mberr;
    logic [7:0]  dl[$];
    logic [7:0]  win[$];
    bit          model_ok = 0;

    function automatic bit in_page(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a <= 32'h8000_0007);
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (a < DEPTH) return mram[a];
        if (in_page(a)) begin
            case (a - 32'h8000_0000)
                0: return {28'b0, mled};
                1: return {24'b0, mdbn};
`ifdef MMIO_TIMER_EN
                2: return mtimer;
                3: return mcmp;
                4: return {31'b0, mflag};
`endif
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge ck) begin
        logic [7:0] syn;
        bit wr, alld, twr, cwr, w1c, hit;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mram[i] = 32'h0;
            mled   = 4'h0;
            mdbn   = 8'h0;
            mtimer = 32'h0;
            mcmp   = 32'hFFFF_FFFF;
            mflag  = 1'b0;
            mirq   = 1'b0;
            mberr  = 1'b0;
            dl     = '{8'h00, 8'h00};
            win.delete();
            for (int i = 0; i < D; i++) win.push_back(8'h00);
            model_ok = 1;
        end else if (model_ok) begin
            syn = dl.pop_front();
            dl.push_back({btn, sw});
            void'(win.pop_front());
            win.push_back(syn);
            for (int b = 0; b < 8; b++) begin
                alld = 1;
                foreach (win[i]) if (win[i][b] == mdbn[b]) alld = 0;
                if (alld) mdbn[b] = ~mdbn[b];
            end
            wr = !rd_wrn;
            if (!(addr < DEPTH) && !in_page(addr)) mberr = 1'b1;
            if (wr && addr < DEPTH) mram[addr] = wdata;
            if (wr && addr == 32'h8000_0000) mled = wdata[3:0];
`ifdef MMIO_TIMER_EN
            twr = wr && addr == 32'h8000_0002;
            cwr = wr && addr == 32'h8000_0003;
            w1c = wr && addr == 32'h8000_0004 && wdata[0];
            hit = (mtimer == mcmp) && !twr;
            mirq = hit;
            if (hit) mflag = 1'b1;
            else if (w1c) mflag = 1'b0;
            mtimer = twr ? 32'h0 : mtimer + 1;
            if (cwr) mcmp = wdata;
`endif
        end
    end

    always @(negedge ck) begin
        if (model_ok) begin
            chk("rdata", rdata, mread(addr));
            chk("led", {28'b0, led}, {28'b0, mled});
            chk("irq", {31'b0, irq}, {31'b0, mirq});
            chk("bus_err", {31'b0, berr}, {31'b0, mberr});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; rd_wrn = 1'b0;
        cyc(1);
        rd_wrn = 1'b1; addr = 32'h0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
        addr = a; rd_wrn = 1'b1;
        #1;
        chk(nm, rdata, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        chk("reset_led", {28'b0, led}, 32'h0);
        chk("reset_berr", {31'b0, berr}, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        rd_chk("reset_ram3", 32'd3, 32'h0);

        wr(32'd3, 32'hDEAD_BEEF);
        rd_chk("ram3", 32'd3, 32'hDEAD_BEEF);
        rd_chk("ram4", 32'd4, 32'h0);
        wr(32'd15, 32'h1234_5678);
        rd_chk("ram15", 32'd15, 32'h1234_5678);

        wr(32'h8000_0000, 32'h5);
        chk("led_out", {28'b0, led}, 32'h5);
        rd_chk("led_reg", 32'h8000_0000, 32'h5);
        wr(32'h8000_0000, 32'hFFFF_FFFA);
        rd_chk("led_upper0", 32'h8000_0000, 32'hA);
        rst_n = 1'b0;
        cyc(1);
        chk("led_reset", {28'b0, led}, 32'h0);
        rst_n = 1'b1;
        rd_chk("ram3_cleared", 32'd3, 32'h0);

        addr = 32'h8000_0001;
        sw = 4'b0001;
        cyc(5);
        rd_chk("in_5cyc", 32'h8000_0001, 32'h00);
        cyc(1);
        rd_chk("in_6cyc", 32'h8000_0001, 32'h01);
        sw = 4'b0000;
        cyc(2);
        sw = 4'b0001;
        cyc(8);
        rd_chk("in_glitch", 32'h8000_0001, 32'h01);
        btn = 4'hA;
        cyc(5);
        rd_chk("btn_5cyc", 32'h8000_0001, 32'h01);
        cyc(1);
        rd_chk("btn_6cyc", 32'h8000_0001, 32'hA1);
        sw = 4'h0; btn = 4'h0;
        cyc(6);
        rd_chk("in_release", 32'h8000_0001, 32'h00);

        rd_chk("unmapped_rd", 32'h0000_0100, 32'h0);
        chk("berr_before", {31'b0, berr}, 32'h0);
        cyc(1);
        chk("berr_set", {31'b0, berr}, 32'h1);
        addr = 32'h0;
        cyc(3);
        chk("berr_sticky", {31'b0, berr}, 32'h1);
        do_reset();
        chk("berr_reset", {31'b0, berr}, 32'h0);
        rd_chk("ram16_unmapped", 32'd16, 32'h0);
        cyc(1);
        chk("berr_ram16", {31'b0, berr}, 32'h1);
        addr = 32'h0;
        do_reset();
        wr(32'h8000_0001, 32'hFF);
        rd_chk("in_ro", 32'h8000_0001, 32'h0);
        wr(32'h8000_0005, 32'hFFFF_FFFF);
        rd_chk("off5", 32'h8000_0005, 32'h0);
        chk("berr_mmio_ok", {31'b0, berr}, 32'h0);

`ifdef MMIO_TIMER_EN
        rd_chk("cmp_reset", 32'h8000_0003, 32'hFFFF_FFFF);
        wr(32'h8000_0003, 32'd10);
        rd_chk("cmp_rd", 32'h8000_0003, 32'd10);
        wr(32'h8000_0002, 32'h0);
        cyc(10);
        chk("irq_pre", {31'b0, irq}, 32'h0);
        cyc(1);
        chk("irq_pulse", {31'b0, irq}, 32'h1);
        rd_chk("status_set", 32'h8000_0004, 32'h1);
        cyc(1);
        chk("irq_single", {31'b0, irq}, 32'h0);
        wr(32'h8000_0004, 32'h1);
        rd_chk("status_w1c", 32'h8000_0004, 32'h0);
        wr(32'h8000_0002, 32'h0);
        cyc(3);
        rd_chk("timer_val", 32'h8000_0002, 32'd3);
        cyc(7);
        wr(32'h8000_0002, 32'h0);
        chk("irq_clear_wins", {31'b0, irq}, 32'h0);
        rd_chk("status_clear_wins", 32'h8000_0004, 32'h0);
        cyc(1);
        chk("irq_none_after", {31'b0, irq}, 32'h0);
        cyc(9);
        wr(32'h8000_0004, 32'h1);
        chk("irq_set_wins", {31'b0, irq}, 32'h1);
        rd_chk("status_set_wins", 32'h8000_0004, 32'h1);
        cyc(3);
`else
        wr(32'h8000_0002, 32'h5);
        wr(32'h8000_0003, 32'h7);
        wr(32'h8000_0004, 32'h1);
        rd_chk("off2_off", 32'h8000_0002, 32'h0);
        rd_chk("off3_off", 32'h8000_0003, 32'h0);
        rd_chk("off4_off", 32'h8000_0004, 32'h0);
        chk("berr_off", {31'b0, berr}, 32'h0);
        cyc(30);
        chk("irq_off", {31'b0, irq}, 32'h0);
`endif

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
